// File: rtl/sync_fifo_pkg.sv
// +----------------------------------------------------------------------+
// | sync_fifo_pkg                                                        |
// | Shared width helper and parameter legality check for sync_fifo.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package sync_fifo_pkg;

    localparam int C_WRAP_BITS = 1;

    // Pointers and the count carry one extra bit so that "full" (count == DEPTH) is representable.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + C_WRAP_BITS;
    endfunction

    function automatic bit params_valid(
        input int data_width,
        input int addr_width,
        input int depth,
        input int almost_full_gap,
        input int almost_empty_gap
    );
        return (data_width >= 1) &&
               (addr_width >= 1) &&
               (depth == (1 << addr_width)) &&
               (almost_full_gap >= 1) &&
               (almost_full_gap <= depth) &&
               (almost_empty_gap >= 0) &&
               (almost_empty_gap < almost_full_gap);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_mem.sv
// +----------------------------------------------------------------------+
// | sync_fifo_mem                                                        |
// | Single-clock storage array: registered write, registered or          |
// | asynchronous read port selected by REG_READ.                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module sync_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter bit REG_READ   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    import sync_fifo_pkg::*;

    localparam int C_WORDS = 1 << ADDR_WIDTH;

    // The array itself is deliberately left without reset.
    logic [DATA_WIDTH-1:0] r_mem [C_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    generate
        if (REG_READ) begin : g_reg_read
            logic [DATA_WIDTH-1:0] r_rdata;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rdata <= '0;
                end else if (re) begin
                    r_rdata <= r_mem[raddr];
                end
            end

            assign rdata = r_rdata;
        end else begin : g_async_read
            assign rdata = r_mem[raddr];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/sync_fifo.sv
// +----------------------------------------------------------------------+
// | sync_fifo                                                            |
// | Single-clock FIFO with count, almost flags and overflow/underflow    |
// | pulses. Define SYNC_FIFO_FWFT_EN for first-word-fall-through mode.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module sync_fifo #(
    parameter int DATA_WIDTH       = 8,
    parameter int ADDR_WIDTH       = 6,
    parameter int DEPTH            = 64,
    parameter int ALMOST_FULL_GAP  = 50,
    parameter int ALMOST_EMPTY_GAP = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    import sync_fifo_pkg::*;

    localparam int                 C_PTR_W  = ptr_width(DEPTH);
    localparam logic [C_PTR_W-1:0] C_ONE    = C_PTR_W'(1);
    localparam logic [C_PTR_W-1:0] C_DEPTH  = C_PTR_W'(DEPTH);
    localparam logic [C_PTR_W-1:0] C_AF_LVL = C_PTR_W'(ALMOST_FULL_GAP);
    localparam logic [C_PTR_W-1:0] C_AE_LVL = C_PTR_W'(ALMOST_EMPTY_GAP);
`ifdef SYNC_FIFO_FWFT_EN
    localparam bit                 C_REG_READ = 1'b0;
`else
    localparam bit                 C_REG_READ = 1'b1;
`endif

    generate
        if (!params_valid(DATA_WIDTH, ADDR_WIDTH, DEPTH, ALMOST_FULL_GAP, ALMOST_EMPTY_GAP)) begin : g_param_check
            $fatal(1, "sync_fifo: illegal parameter combination");
        end
    endgenerate

    logic [C_PTR_W-1:0]    r_wr_ptr;
    logic [C_PTR_W-1:0]    r_rd_ptr;
    logic [C_PTR_W-1:0]    r_count;
    logic [C_PTR_W-1:0]    w_count_next;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_almost_full;
    logic                  r_almost_empty;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty_next;
    logic                  w_mem_re;
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    // Accept decisions use the registered flags, so a blocked request never moves a pointer.
    assign w_push       = wr_en & ~r_full;
    assign w_pop        = rd_en & ~r_empty;
    assign w_count_next = r_count + C_PTR_W'(w_push) - C_PTR_W'(w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_ONE;
            end
            r_count        <= w_count_next;
            r_full         <= (w_count_next == C_DEPTH);
            r_empty        <= w_empty_next;
            r_almost_full  <= (w_count_next >= C_AF_LVL);
            r_almost_empty <= (w_count_next <= C_AE_LVL);
            r_overflow     <= wr_en & r_full;
            r_underflow    <= rd_en & r_empty;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word lives in r_head; r_empty doubles as its valid bit.
    logic [DATA_WIDTH-1:0] r_head;
    logic                  w_mem_has_data;
    logic                  w_load;

    assign w_mem_has_data = (r_wr_ptr != r_rd_ptr);
    assign w_load         = (r_empty | w_pop) & w_mem_has_data;
    assign w_mem_re       = w_load;
    assign w_empty_next   = ~((~r_empty & ~w_pop) | w_mem_has_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_head   <= '0;
        end else if (w_load) begin
            r_rd_ptr <= r_rd_ptr + C_ONE;
            r_head   <= w_mem_rdata;
        end
    end

    assign dout = r_head;
`else
    assign w_mem_re     = w_pop;
    assign w_empty_next = (w_count_next == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + C_ONE;
        end
    end

    assign dout = w_mem_rdata;
`endif

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG_READ   (C_REG_READ)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_push),
        .waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .wdata (din),
        .re    (w_mem_re),
        .raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .rdata (w_mem_rdata)
    );

    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

`default_nettype wire
